rv_pipe_slice: RTL and testbench

RV_PIPE_SLICE -- requirements
Module: rv_pipe_slice

---
 rtl/rv_pipe_slice.sv | 133 +++++++++++++
 tb/tb_rv_pipe_slice.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_pipe_slice.sv
// rv_pipe_slice: valid/ready pipeline slice with flush and a saturating downstream-stall counter.
// Define RV_PIPE_SKID_EN for a 2-entry skid buffer with registered ready; otherwise a single register stage.
//   state | meaning
//   EMPTY | nothing held, o_ps_valid low
//   ONE   | head entry valid, skid slot free (skid build)
//   TWO   | head and skid entries valid, upstream held off (skid build)
//   FULL  | head entry valid (single-register build)
module rv_pipe_slice #(
  parameter int DW  = 64,
  parameter int CW  = 16,
  parameter int SCW = 16
) (
  input  logic           i_ps_clk,
  input  logic           i_ps_rst,
  input  logic           i_ps_flush,
  input  logic           i_ps_valid,
  output logic           o_ps_ready,
  input  logic [DW-1:0]  i_ps_data,
  input  logic [CW-1:0]  i_ps_ctrl,
  output logic           o_ps_valid,
  input  logic           i_ps_ready,
  output logic [DW-1:0]  o_ps_data,
  output logic [CW-1:0]  o_ps_ctrl,
  output logic [SCW-1:0] o_ps_stall_cnt
);

`ifdef RV_PIPE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`else
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
`endif

  state_t         state, state_nxt;
  logic           push, pop;
  logic [DW-1:0]  head_data;
  logic [CW-1:0]  head_ctrl;
  logic [SCW-1:0] stall_cnt;

  assign push = i_ps_valid & o_ps_ready & ~i_ps_flush;
  assign pop  = o_ps_valid & i_ps_ready;

  always_ff @(posedge i_ps_clk) begin
    if (i_ps_rst) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_ps_flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
`ifdef RV_PIPE_SKID_EN
        EMPTY:   if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop)      state_nxt = TWO;
          else if (pop && !push) state_nxt = EMPTY;
        end
        TWO:     if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
`else
        EMPTY:   if (push) state_nxt = FULL;
        FULL:    if (pop && !push) state_nxt = EMPTY;
        default: state_nxt = EMPTY;
`endif
      endcase
    end
  end

`ifdef RV_PIPE_SKID_EN
  logic [DW-1:0] skid_data;
  logic [CW-1:0] skid_ctrl;
  logic          ready_q;

  // ready_q tracks the next state so upstream sees ready without any path from i_ps_ready.
  always_ff @(posedge i_ps_clk) begin
    if (i_ps_rst) begin
      head_data <= '0;
      head_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      ready_q   <= 1'b1;
    end else begin
      ready_q <= (state_nxt != TWO);
      if (i_ps_flush) begin
        head_data <= '0;
        head_ctrl <= '0;
        skid_data <= '0;
        skid_ctrl <= '0;
      end else if (push && (state == EMPTY || pop)) begin
        head_data <= i_ps_data;
        head_ctrl <= i_ps_ctrl;
      end else if (push) begin
        skid_data <= i_ps_data;
        skid_ctrl <= i_ps_ctrl;
      end else if (pop && state == TWO) begin
        head_data <= skid_data;
        head_ctrl <= skid_ctrl;
      end
    end
  end
`else
  always_ff @(posedge i_ps_clk) begin
    if (i_ps_rst || i_ps_flush) begin
      head_data <= '0;
      head_ctrl <= '0;
    end else if (push) begin
      head_data <= i_ps_data;
      head_ctrl <= i_ps_ctrl;
    end
  end
`endif

  always_ff @(posedge i_ps_clk) begin
    if (i_ps_rst)
      stall_cnt <= '0;
    else if (o_ps_valid && !i_ps_ready && !i_ps_flush && stall_cnt != '1)
      stall_cnt <= stall_cnt + SCW'(1);
  end

  always_comb begin
    o_ps_valid     = (state != EMPTY);
`ifdef RV_PIPE_SKID_EN
    o_ps_ready     = ready_q & ~i_ps_rst;
`else
    o_ps_ready     = ~i_ps_rst & ((state == EMPTY) | i_ps_ready);
`endif
    o_ps_data      = head_data;
    o_ps_ctrl      = head_ctrl;
    o_ps_stall_cnt = stall_cnt;
  end

endmodule

// File: tb/tb_rv_pipe_slice.sv
// Scoreboard bench for rv_pipe_slice: pushes recorded as expected entries, pops compared in order.
// Expectations follow RV_PIPE_SKID_EN when it is defined for the build.
module tb_rv_pipe_slice;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready;
  logic [63:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_ready, out_valid;
  logic [63:0] out_data;
  logic [15:0] out_ctrl;
  logic [15:0] stall_cnt;
  logic        sat_ready, sat_valid;
  logic [63:0] sat_data;
  logic [15:0] sat_ctrl;
  logic [3:0]  sat_cnt;

`ifdef RV_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  rv_pipe_slice #(.DW(64), .CW(16), .SCW(16)) dut (
    .i_ps_clk(clk), .i_ps_rst(rst), .i_ps_flush(flush), .i_ps_valid(in_valid),
    .o_ps_ready(out_ready), .i_ps_data(in_data), .i_ps_ctrl(in_ctrl),
    .o_ps_valid(out_valid), .i_ps_ready(in_ready), .o_ps_data(out_data),
    .o_ps_ctrl(out_ctrl), .o_ps_stall_cnt(stall_cnt));

  rv_pipe_slice #(.DW(64), .CW(16), .SCW(4)) dut_sat (
    .i_ps_clk(clk), .i_ps_rst(rst), .i_ps_flush(flush), .i_ps_valid(in_valid),
    .o_ps_ready(sat_ready), .i_ps_data(in_data), .i_ps_ctrl(in_ctrl),
    .o_ps_valid(sat_valid), .i_ps_ready(in_ready), .o_ps_data(sat_data),
    .o_ps_ctrl(sat_ctrl), .o_ps_stall_cnt(sat_cnt));

  typedef struct packed {logic [63:0] d; logic [15:0] c;} ent_t;
  ent_t exp_q[$];
  ent_t got_q[$];
  int   errors = 0;
  int   checks = 0;

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    #1;
    if (in_valid && out_ready && !flush) exp_q.push_back({in_data, in_ctrl});
    if (out_valid && in_ready) got_q.push_back({out_data, out_ctrl});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
  endtask

  task automatic pulse_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; in_valid = 1'b1; in_data = 64'hDEAD; in_ctrl = 16'hBEEF;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rst_data: got %h want 0", out_data); end
    checks++; if (out_ctrl !== 16'h0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", out_ctrl); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL rst_stall: got %h want 0", stall_cnt); end
    checks++; if (out_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b want 0", out_ready); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_release: got %b want 1", out_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %b want 0", out_valid); end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_stream();
    in_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i); in_ctrl = 16'(16'h0100 + i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'(i))
        begin errors++; $display("FAIL stream_latency: got v=%b d=%h want v=1 d=%h", out_valid, out_data, 64'(i)); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b want 0", out_valid); end
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL stream_count: got %0d want 8", got_q.size()); end
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== ent_t'({64'(k + 1), 16'(16'h0100 + k + 1)}))
        begin errors++; $display("FAIL stream_order[%0d]: got %h want %0d", k, got_q[k].d, k + 1); end
    end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL stream_stall: got %0d want 0", stall_cnt); end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_backpressure();
    logic [63:0] items [3];
    int idx, sz;
    items[0] = 64'hA; items[1] = 64'hB; items[2] = 64'hC;
    idx = 0;
    pulse_reset();
    in_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid = (idx < 3);
      in_data  = (idx < 3) ? items[idx] : 64'h0;
      in_ctrl  = 16'(16'h00A0 + idx);
      sz = exp_q.size();
      tick();
      if (exp_q.size() > sz) idx++;
      if (cyc == 0) begin
        checks++;
        if (out_ready !== SKID)
          begin errors++; $display("FAIL bp_ready_one: got %b want %b", out_ready, SKID); end
      end
      if (cyc == 1) begin
        checks++;
        if (out_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", out_ready); end
      end
      checks++;
      if (out_data !== 64'hA) begin errors++; $display("FAIL bp_hold: got %h want a", out_data); end
    end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_stall: got %0d want 3", stall_cnt); end
    in_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && (idx < 3 || out_valid); cyc++) begin
      in_valid = (idx < 3);
      in_data  = (idx < 3) ? items[idx] : 64'h0;
      in_ctrl  = 16'(16'h00A0 + idx);
      sz = exp_q.size();
      tick();
      if (exp_q.size() > sz) idx++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx < 3 || out_valid) begin errors++; $display("FAIL bp_drain_timeout: got idx=%0d want 3", idx); end
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", got_q.size()); end
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k].d !== items[k]) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", k, got_q[k].d, items[k]); end
    end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_stall_after: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_flush();
    pulse_reset();
    in_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h21; in_ctrl = 16'h0021;
    tick();
    in_data = 64'h22; in_ctrl = 16'h0022;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
    flush = 1'b1; in_valid = 1'b1; in_data = 64'h55; in_ctrl = 16'hFFFF;
    #1;
    checks++; if (out_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", out_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    checks++; if (out_ctrl !== 16'h0) begin errors++; $display("FAIL flush_ctrl: got %h want 0", out_ctrl); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL flush_data: got %h want 0", out_data); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_stall: got %0d want 1", stall_cnt); end
    checks++;
    if (exp_q.size() != (SKID ? 2 : 1)) begin errors++; $display("FAIL flush_accept: got %0d want %0d", exp_q.size(), SKID ? 2 : 1); end
    flush = 1'b0; in_valid = 1'b0; in_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL flush_leak: got %0d want 0 emitted", got_q.size()); end
    checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after: got %b want 1", out_ready); end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_mid_stall();
    pulse_reset();
    in_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h31; in_ctrl = 16'h0031;
    tick();
    in_data = 64'h32; in_ctrl = 16'h0032;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL rms_stall: got %0d want 5", stall_cnt); end
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_ready = 1'b1; in_data = 64'h77; in_ctrl = 16'h0077;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rms_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rms_data: got %h want 0", out_data); end
    checks++; if (out_ctrl !== 16'h0) begin errors++; $display("FAIL rms_ctrl: got %h want 0", out_ctrl); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL rms_cnt: got %0d want 0", stall_cnt); end
    checks++; if (out_ready !== 1'b0) begin errors++; $display("FAIL rms_ready_low: got %b want 0", out_ready); end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
    #1;
    checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL rms_ready_release: got %b want 1", out_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rms_no_entries: got %b want 0", out_valid); end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_saturation();
    pulse_reset();
    in_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h41; in_ctrl = 16'h0041;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) begin
        checks++; if (sat_cnt !== 4'hE) begin errors++; $display("FAIL sat_14: got %h want e", sat_cnt); end
      end
      if (k == 15) begin
        checks++; if (sat_cnt !== 4'hF) begin errors++; $display("FAIL sat_15: got %h want f", sat_cnt); end
      end
    end
    checks++; if (sat_cnt !== 4'hF) begin errors++; $display("FAIL sat_20: got %h want f", sat_cnt); end
    checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide: got %0d want 20", stall_cnt); end
    for (int k = 0; k < 3; k++) tick();
    checks++; if (sat_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold: got %h want f", sat_cnt); end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_ready = ($urandom_range(0, 3) != 0);
      in_data  = {$urandom, $urandom};
      in_ctrl  = 16'($urandom);
      tick();
    end
    in_valid = 1'b0; in_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_timeout: got valid=%b want 0", out_valid); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", k, got_q[k], exp_q[k]); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
